// File: rtl/vx_sched_pkg.sv
// rtl/vx_sched_pkg.sv - shared encodings and width helpers for the warp scheduler
package vx_sched_pkg;

  typedef enum logic [1:0] {
    WCTL_TMC    = 2'd0,
    WCTL_WSPAWN = 2'd1,
    WCTL_BAR    = 2'd2,
    WCTL_RSVD   = 2'd3
  } wctl_op_e;

  localparam int POLICY_RR  = 0;
  localparam int POLICY_GTO = 1;
  localparam int AGE_W      = 8;

  function automatic int nw_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int nb_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int popcount32(input logic [31:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/vx_warp_picker.sv
// rtl/vx_warp_picker.sv - combinational grant selection (round-robin or greedy-then-oldest)
module vx_warp_picker
  import vx_sched_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int POLICY    = POLICY_RR,
  localparam int NW_BITS  = nw_bits(NUM_WARPS)
) (
  input  logic [NUM_WARPS-1:0]            ready,
  input  logic [NUM_WARPS-1:0][AGE_W-1:0] ages,
  input  logic [NW_BITS-1:0]              last_grant,
  output logic                            valid,
  output logic [NW_BITS-1:0]              wid
);

  logic [AGE_W-1:0]   best_age;
  logic [NW_BITS-1:0] cand;

  always_comb begin
    valid    = 1'b0;
    wid      = '0;
    best_age = '0;
    cand     = '0;
    if (POLICY == POLICY_GTO && ready[last_grant]) begin
      valid = 1'b1;
      wid   = last_grant;
    end else if (POLICY == POLICY_GTO) begin
      // strict compare keeps the lowest index on equal ages
      for (int i = 0; i < NUM_WARPS; i++) begin
        if (ready[i] && (!valid || ages[i] > best_age)) begin
          valid    = 1'b1;
          wid      = NW_BITS'(i);
          best_age = ages[i];
        end
      end
    end else begin
      // walk backwards so the nearest successor of last_grant is the final winner
      for (int k = NUM_WARPS; k >= 1; k--) begin
        cand = NW_BITS'((int'(last_grant) + k) % NUM_WARPS);
        if (ready[cand]) begin
          valid = 1'b1;
          wid   = cand;
        end
      end
    end
  end

endmodule

// File: rtl/vx_warp_sched_gen.sv
// rtl/vx_warp_sched_gen.sv - warp scheduler: per-warp state, barriers and registered fetch request
module vx_warp_sched_gen
  import vx_sched_pkg::*;
#(
  parameter int          NUM_WARPS    = 4,
  parameter int          NUM_THREADS  = 4,
  parameter int          NUM_BARRIERS = 4,
  parameter int          POLICY       = 0,
  parameter logic [31:0] STARTUP_ADDR = 32'h80000000,
  localparam int         NW_BITS      = nw_bits(NUM_WARPS),
  localparam int         NB_BITS      = nb_bits(NUM_BARRIERS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wctl_valid,
  input  logic [1:0]             wctl_op,
  input  logic [NW_BITS-1:0]     wctl_wid,
  input  logic [NUM_THREADS-1:0] wctl_tmask,
  input  logic [NUM_WARPS-1:0]   wctl_wmask,
  input  logic [31:0]            wctl_pc,
  input  logic [NB_BITS-1:0]     wctl_bar_id,
  input  logic [NW_BITS-1:0]     wctl_bar_size_m1,
  input  logic                   wstall_valid,
  input  logic [NW_BITS-1:0]     wstall_wid,
  input  logic                   branch_valid,
  input  logic [NW_BITS-1:0]     branch_wid,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_dest,
  input  logic                   ifetch_rsp_valid,
  input  logic [NW_BITS-1:0]     ifetch_rsp_wid,
  input  logic [31:0]            ifetch_rsp_pc,
  output logic                   ifetch_req_valid,
  input  logic                   ifetch_req_ready,
  output logic [NW_BITS-1:0]     ifetch_req_wid,
  output logic [NUM_THREADS-1:0] ifetch_req_tmask,
  output logic [31:0]            ifetch_req_pc,
  output logic [NUM_WARPS-1:0]   active_warps,
  output logic                   busy
);

  logic [NUM_WARPS-1:0]                   active_q, stalled_q, lock_q;
  logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] bar_q;
  logic [NUM_WARPS-1:0][31:0]             pc_q;
  logic [NUM_WARPS-1:0][NUM_THREADS-1:0]  tmask_q;
  logic [NUM_WARPS-1:0][AGE_W-1:0]        age_q;
  logic [NW_BITS-1:0]                     last_q;

  logic                   req_valid_q;
  logic [NW_BITS-1:0]     req_wid_q;
  logic [NUM_THREADS-1:0] req_tmask_q;
  logic [31:0]            req_pc_q;

  logic [NUM_WARPS-1:0] bar_any, ready;
  logic                 pick_valid, can_load, grant;
  logic [NW_BITS-1:0]   pick_wid;
  wctl_op_e             op;
  logic                 is_tmc, is_spawn, is_bar, bar_ok, bar_release;

  always_comb begin
    bar_any = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) bar_any = bar_any | bar_q[b];
  end

  assign ready = active_q & ~stalled_q & ~lock_q & ~bar_any;

  vx_warp_picker #(
    .NUM_WARPS (NUM_WARPS),
    .POLICY    (POLICY)
  ) u_picker (
    .ready      (ready),
    .ages       (age_q),
    .last_grant (last_q),
    .valid      (pick_valid),
    .wid        (pick_wid)
  );

  // the output register may only be reloaded once it is empty or being drained
  assign can_load = ~req_valid_q | ifetch_req_ready;
  assign grant    = can_load & pick_valid;

  assign op          = wctl_op_e'(wctl_op);
  assign is_tmc      = wctl_valid & (op == WCTL_TMC);
  assign is_spawn    = wctl_valid & (op == WCTL_WSPAWN);
  assign is_bar      = wctl_valid & (op == WCTL_BAR);
  assign bar_ok      = is_bar & (int'(wctl_bar_id) < NUM_BARRIERS);
  assign bar_release = bar_ok &&
                       (popcount32(32'(bar_q[wctl_bar_id])) == int'(wctl_bar_size_m1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_valid_q <= 1'b0;
      req_wid_q   <= '0;
      req_tmask_q <= '0;
      req_pc_q    <= '0;
      active_q    <= NUM_WARPS'(1);
      stalled_q   <= '0;
      lock_q      <= '0;
      bar_q       <= '0;
      age_q       <= '0;
      pc_q        <= '0;
      pc_q[0]     <= STARTUP_ADDR;
      tmask_q     <= '0;
      tmask_q[0]  <= NUM_THREADS'(1);
      last_q      <= NW_BITS'(NUM_WARPS - 1);
    end else begin
      if (can_load) begin
        req_valid_q <= pick_valid;
        if (pick_valid) begin
          req_wid_q   <= pick_wid;
          req_tmask_q <= tmask_q[pick_wid];
          req_pc_q    <= pc_q[pick_wid];
        end
      end

      for (int i = 0; i < NUM_WARPS; i++) begin
        if (grant && pick_wid == NW_BITS'(i))      age_q[i] <= '0;
        else if (ready[i] && age_q[i] != '1)        age_q[i] <= age_q[i] + 1'b1;
      end

      if (ifetch_rsp_valid) begin
        lock_q[ifetch_rsp_wid] <= 1'b0;
        pc_q[ifetch_rsp_wid]   <= ifetch_rsp_pc + 32'd4;
      end
      if (grant) begin
        lock_q[pick_wid] <= 1'b1;
        last_q           <= pick_wid;
      end

      // later assignments win: stall set first, then branch/wctl clears and branch pc
      if (wstall_valid) stalled_q[wstall_wid] <= 1'b1;
      if (branch_valid) begin
        stalled_q[branch_wid] <= 1'b0;
        if (branch_taken) pc_q[branch_wid] <= branch_dest;
      end

      if (is_tmc) begin
        tmask_q[wctl_wid]   <= wctl_tmask;
        active_q[wctl_wid]  <= |wctl_tmask;
        stalled_q[wctl_wid] <= 1'b0;
      end

      if (is_bar) begin
        stalled_q[wctl_wid] <= 1'b0;
        if (bar_release)  bar_q[wctl_bar_id]           <= '0;
        else if (bar_ok)  bar_q[wctl_bar_id][wctl_wid] <= 1'b1;
      end

      if (is_spawn) begin
        active_q <= wctl_wmask;
        for (int i = 1; i < NUM_WARPS; i++) begin
          if (wctl_wmask[i]) begin
            pc_q[i]    <= wctl_pc;
            tmask_q[i] <= NUM_THREADS'(1);
            age_q[i]   <= '0;
          end
        end
      end
    end
  end

  assign ifetch_req_valid = req_valid_q;
  assign ifetch_req_wid   = req_wid_q;
  assign ifetch_req_tmask = req_tmask_q;
  assign ifetch_req_pc    = req_pc_q;
  assign active_warps     = active_q;
  assign busy             = |active_q;

endmodule

// File: tb/tb_vx_warp_sched_gen.sv
// tb/tb_vx_warp_sched_gen.sv - self-checking bench for vx_warp_sched_gen (round-robin and GTO instances)
module tb_vx_warp_sched_gen;
  localparam int NW = 4;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        wctl_valid;
  logic [1:0]  wctl_op, wctl_wid, wctl_bar_id, wctl_bar_size_m1;
  logic [3:0]  wctl_tmask, wctl_wmask;
  logic [31:0] wctl_pc;
  logic        wstall_valid;
  logic [1:0]  wstall_wid;
  logic        branch_valid, branch_taken;
  logic [1:0]  branch_wid;
  logic [31:0] branch_dest;
  logic        ifetch_rsp_valid;
  logic [1:0]  ifetch_rsp_wid;
  logic [31:0] ifetch_rsp_pc;
  logic        ifetch_req_ready;

  logic        req_valid [2];
  logic [1:0]  req_wid   [2];
  logic [3:0]  req_tmask [2];
  logic [31:0] req_pc    [2];
  logic [3:0]  act_w     [2];
  logic        bsy       [2];

  for (genvar p = 0; p < 2; p++) begin : g_dut
    vx_warp_sched_gen #(.POLICY(p)) dut (
      .clk(clk), .reset_n(reset_n),
      .wctl_valid(wctl_valid), .wctl_op(wctl_op), .wctl_wid(wctl_wid),
      .wctl_tmask(wctl_tmask), .wctl_wmask(wctl_wmask), .wctl_pc(wctl_pc),
      .wctl_bar_id(wctl_bar_id), .wctl_bar_size_m1(wctl_bar_size_m1),
      .wstall_valid(wstall_valid), .wstall_wid(wstall_wid),
      .branch_valid(branch_valid), .branch_wid(branch_wid),
      .branch_taken(branch_taken), .branch_dest(branch_dest),
      .ifetch_rsp_valid(ifetch_rsp_valid), .ifetch_rsp_wid(ifetch_rsp_wid),
      .ifetch_rsp_pc(ifetch_rsp_pc),
      .ifetch_req_valid(req_valid[p]), .ifetch_req_ready(ifetch_req_ready),
      .ifetch_req_wid(req_wid[p]), .ifetch_req_tmask(req_tmask[p]),
      .ifetch_req_pc(req_pc[p]), .active_warps(act_w[p]), .busy(bsy[p])
    );
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // reference model, one copy per instance (0 = round-robin, 1 = GTO)
  bit          m_act [2][NW];
  bit          m_st  [2][NW];
  bit          m_lk  [2][NW];
  bit          m_bar [2][NB][NW];
  bit [31:0]   m_pc  [2][NW];
  bit [3:0]    m_tm  [2][NW];
  int          m_age [2][NW];
  int          m_last[2];
  bit          m_ov  [2];
  int          m_owid[2];
  bit [3:0]    m_otm [2];
  bit [31:0]   m_opc [2];

  task automatic model_reset(input int p);
    for (int i = 0; i < NW; i++) begin
      m_act[p][i] = (i == 0);
      m_st[p][i]  = 0;
      m_lk[p][i]  = 0;
      m_pc[p][i]  = (i == 0) ? 32'h80000000 : 32'h0;
      m_tm[p][i]  = (i == 0) ? 4'd1 : 4'd0;
      m_age[p][i] = 0;
      for (int b = 0; b < NB; b++) m_bar[p][b][i] = 0;
    end
    m_last[p] = NW - 1;
    m_ov[p] = 0;
  endtask

  function automatic int pick(input int p, input bit [NW-1:0] rdy);
    int best = -1;
    if (p == 0) begin
      for (int k = 1; k <= NW; k++)
        if (rdy[(m_last[p] + k) % NW]) return (m_last[p] + k) % NW;
      return -1;
    end
    if (rdy[m_last[p]]) return m_last[p];
    for (int i = 0; i < NW; i++)
      if (rdy[i] && (best < 0 || m_age[p][i] > m_age[p][best])) best = i;
    return best;
  endfunction

  task automatic model_step(input int p);
    bit [NW-1:0] rdy;
    bit blocked;
    int g, cnt;
    for (int i = 0; i < NW; i++) begin
      blocked = 0;
      for (int b = 0; b < NB; b++) blocked |= m_bar[p][b][i];
      rdy[i] = m_act[p][i] && !m_st[p][i] && !m_lk[p][i] && !blocked;
    end
    g = -1;
    if (!m_ov[p] || ifetch_req_ready) begin
      g = pick(p, rdy);
      m_ov[p] = (g >= 0);
      if (g >= 0) begin
        m_owid[p] = g;
        m_otm[p]  = m_tm[p][g];
        m_opc[p]  = m_pc[p][g];
      end
    end
    for (int i = 0; i < NW; i++) begin
      if (i == g) m_age[p][i] = 0;
      else if (rdy[i] && m_age[p][i] < 255) m_age[p][i]++;
    end
    if (ifetch_rsp_valid) begin
      m_lk[p][ifetch_rsp_wid] = 0;
      m_pc[p][ifetch_rsp_wid] = ifetch_rsp_pc + 32'd4;
    end
    if (g >= 0) begin
      m_lk[p][g] = 1;
      m_last[p] = g;
    end
    if (wstall_valid) m_st[p][wstall_wid] = 1;
    if (branch_valid) begin
      m_st[p][branch_wid] = 0;
      if (branch_taken) m_pc[p][branch_wid] = branch_dest;
    end
    if (wctl_valid) begin
      case (wctl_op)
        2'd0: begin
          m_tm[p][wctl_wid]  = wctl_tmask;
          m_act[p][wctl_wid] = (wctl_tmask != 0);
          m_st[p][wctl_wid]  = 0;
        end
        2'd1: begin
          for (int i = 0; i < NW; i++) m_act[p][i] = wctl_wmask[i];
          for (int i = 1; i < NW; i++)
            if (wctl_wmask[i]) begin
              m_pc[p][i] = wctl_pc;
              m_tm[p][i] = 4'd1;
              m_age[p][i] = 0;
            end
        end
        2'd2: begin
          m_st[p][wctl_wid] = 0;
          if (int'(wctl_bar_id) < NB) begin
            cnt = 0;
            for (int i = 0; i < NW; i++) cnt += m_bar[p][wctl_bar_id][i];
            if (cnt == int'(wctl_bar_size_m1))
              for (int i = 0; i < NW; i++) m_bar[p][wctl_bar_id][i] = 0;
            else m_bar[p][wctl_bar_id][wctl_wid] = 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_model(input int p);
    bit [3:0] a;
    for (int i = 0; i < NW; i++) a[i] = m_act[p][i];
    chk($sformatf("p%0d model valid", p), 32'(req_valid[p]), 32'(m_ov[p]));
    if (m_ov[p]) begin
      chk($sformatf("p%0d model wid", p), 32'(req_wid[p]), 32'(m_owid[p]));
      chk($sformatf("p%0d model tmask", p), 32'(req_tmask[p]), 32'(m_otm[p]));
      chk($sformatf("p%0d model pc", p), req_pc[p], m_opc[p]);
    end
    chk($sformatf("p%0d model active", p), 32'(act_w[p]), 32'(a));
    chk($sformatf("p%0d model busy", p), 32'(bsy[p]), 32'(a != 0));
  endtask

  task automatic idle();
    wctl_valid = 0; wctl_op = 0; wctl_wid = 0; wctl_tmask = 0; wctl_wmask = 0;
    wctl_pc = 0; wctl_bar_id = 0; wctl_bar_size_m1 = 0;
    wstall_valid = 0; wstall_wid = 0;
    branch_valid = 0; branch_wid = 0; branch_taken = 0; branch_dest = 0;
    ifetch_rsp_valid = 0; ifetch_rsp_wid = 0; ifetch_rsp_pc = 0;
    ifetch_req_ready = 1;
  endtask

  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk); #1;
    check_model(0);
    check_model(1);
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    model_reset(0);
    model_reset(1);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1;
  endtask

  task automatic wctl(input logic [1:0] op, input logic [1:0] wid, input logic [3:0] wmask,
                      input logic [31:0] pc, input logic [1:0] bid, input logic [1:0] sz);
    wctl_valid = 1; wctl_op = op; wctl_wid = wid; wctl_wmask = wmask;
    wctl_pc = pc; wctl_bar_id = bid; wctl_bar_size_m1 = sz;
  endtask

  task automatic rsp(input logic [1:0] wid, input logic [31:0] pc);
    ifetch_rsp_valid = 1; ifetch_rsp_wid = wid; ifetch_rsp_pc = pc;
  endtask

  task automatic expq(input int p, input string nm, input bit v, input int wid, input logic [31:0] pc);
    chk({nm, " valid"}, 32'(req_valid[p]), 32'(v));
    if (v) begin
      chk({nm, " wid"}, 32'(req_wid[p]), 32'(wid));
      chk({nm, " pc"}, req_pc[p], pc);
    end
  endtask

  typedef struct {
    bit        wv;
    bit [1:0]  op;
    bit [3:0]  wmask;
    bit [31:0] wpc;
    bit        rv;
    bit [1:0]  rwid;
    bit [31:0] rpc;
    bit        ev;
    int        ewid;
    bit [3:0]  etm;
    bit [31:0] epc;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1, 2'd1, 4'hf, 32'h100, 0, 2'd0, 32'h0,        1, 0, 4'd1, 32'h80000000};
    tbl[1] = '{0, 2'd0, 4'h0, 32'h0,   1, 2'd0, 32'h80000000, 1, 1, 4'd1, 32'h100};
    tbl[2] = '{0, 2'd0, 4'h0, 32'h0,   1, 2'd1, 32'h100,      1, 2, 4'd1, 32'h100};
    tbl[3] = '{0, 2'd0, 4'h0, 32'h0,   1, 2'd2, 32'h100,      1, 3, 4'd1, 32'h100};
    tbl[4] = '{0, 2'd0, 4'h0, 32'h0,   1, 2'd3, 32'h100,      1, 0, 4'd1, 32'h80000004};
    tbl[5] = '{0, 2'd0, 4'h0, 32'h0,   1, 2'd0, 32'h80000004, 1, 1, 4'd1, 32'h104};

    do_reset();
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("p%0d reset valid", p), 32'(req_valid[p]), 32'd0);
      chk($sformatf("p%0d reset active", p), 32'(act_w[p]), 32'd1);
      chk($sformatf("p%0d reset busy", p), 32'(bsy[p]), 32'd1);
    end

    // round-robin after WSPAWN with responses returned every cycle
    for (int t = 0; t < 6; t++) begin
      wctl_valid = tbl[t].wv; wctl_op = tbl[t].op; wctl_wmask = tbl[t].wmask; wctl_pc = tbl[t].wpc;
      ifetch_rsp_valid = tbl[t].rv; ifetch_rsp_wid = tbl[t].rwid; ifetch_rsp_pc = tbl[t].rpc;
      cycle();
      chk($sformatf("tbl%0d valid", t), 32'(req_valid[0]), 32'(tbl[t].ev));
      chk($sformatf("tbl%0d wid", t), 32'(req_wid[0]), 32'(tbl[t].ewid));
      chk($sformatf("tbl%0d tmask", t), 32'(req_tmask[0]), 32'(tbl[t].etm));
      chk($sformatf("tbl%0d pc", t), req_pc[0], tbl[t].epc);
    end

    // same-cycle response and taken branch on warp 1
    do_reset();
    wctl(2'd1, 2'd0, 4'b0010, 32'h200, 2'd0, 2'd0); cycle(); expq(0, "A0", 1, 0, 32'h80000000);
    cycle(); expq(0, "A1", 1, 1, 32'h200);
    rsp(2'd1, 32'h200);
    branch_valid = 1; branch_wid = 2'd1; branch_taken = 1; branch_dest = 32'h400;
    cycle(); expq(0, "A2", 0, 0, 32'h0);
    cycle(); expq(0, "A3 branch wins", 1, 1, 32'h400);

    // back-pressure for five cycles
    do_reset();
    wctl(2'd1, 2'd0, 4'hf, 32'h300, 2'd0, 2'd0); ifetch_req_ready = 0; cycle();
    expq(0, "B0", 1, 0, 32'h80000000);
    for (int i = 0; i < 5; i++) begin
      ifetch_req_ready = 0;
      cycle();
      expq(0, $sformatf("B hold%0d", i), 1, 0, 32'h80000000);
      chk($sformatf("B hold%0d tmask", i), 32'(req_tmask[0]), 32'd1);
    end
    cycle(); expq(0, "B6", 1, 1, 32'h300);
    cycle(); expq(0, "B7", 1, 2, 32'h300);

    // barrier 1 with size_m1 2 across warps 0,1,2
    do_reset();
    wctl(2'd1, 2'd0, 4'b0111, 32'h500, 2'd0, 2'd0); cycle(); expq(0, "C0", 1, 0, 32'h80000000);
    wctl(2'd2, 2'd0, 4'h0, 32'h0, 2'd1, 2'd2); rsp(2'd0, 32'h80000000); cycle();
    expq(0, "C1", 1, 1, 32'h500);
    wctl(2'd2, 2'd1, 4'h0, 32'h0, 2'd1, 2'd2); rsp(2'd1, 32'h500); cycle();
    expq(0, "C2", 1, 2, 32'h500);
    rsp(2'd2, 32'h500); cycle(); expq(0, "C3 blocked", 0, 0, 32'h0);
    wctl(2'd2, 2'd2, 4'h0, 32'h0, 2'd1, 2'd2); cycle(); expq(0, "C4", 1, 2, 32'h504);
    cycle(); expq(0, "C5 released", 1, 0, 32'h80000004);
    cycle(); expq(0, "C6 released", 1, 1, 32'h504);

    // greedy-then-oldest on the POLICY=1 instance
    do_reset();
    wctl(2'd1, 2'd0, 4'hf, 32'h600, 2'd0, 2'd0); cycle(); expq(1, "D0", 1, 0, 32'h80000000);
    rsp(2'd0, 32'h80000000); cycle(); expq(1, "D1", 1, 1, 32'h600);
    rsp(2'd1, 32'h600); cycle(); expq(1, "D2", 1, 2, 32'h600);
    rsp(2'd2, 32'h600); ifetch_req_ready = 0; cycle(); expq(1, "D3 hold", 1, 2, 32'h600);
    cycle(); expq(1, "D4 greedy", 1, 2, 32'h604);
    rsp(2'd2, 32'h604); wstall_valid = 1; wstall_wid = 2'd2; ifetch_req_ready = 0; cycle();
    expq(1, "D5 hold", 1, 2, 32'h604);
    cycle(); expq(1, "D6 oldest", 1, 3, 32'h600);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      wctl_valid = ($urandom_range(0, 7) == 0);
      wctl_op = 2'($urandom_range(0, 3));
      wctl_wid = 2'($urandom_range(0, 3));
      wctl_tmask = 4'($urandom_range(0, 15));
      wctl_wmask = 4'($urandom_range(0, 15));
      wctl_pc = $urandom & 32'hffff_fffc;
      wctl_bar_id = 2'($urandom_range(0, 3));
      wctl_bar_size_m1 = 2'($urandom_range(0, 3));
      wstall_valid = ($urandom_range(0, 5) == 0);
      wstall_wid = 2'($urandom_range(0, 3));
      branch_valid = ($urandom_range(0, 4) == 0);
      branch_wid = 2'($urandom_range(0, 3));
      branch_taken = 1'($urandom_range(0, 1));
      branch_dest = $urandom & 32'hffff_fffc;
      ifetch_rsp_valid = 1'($urandom_range(0, 1));
      ifetch_rsp_wid = 2'($urandom_range(0, 3));
      ifetch_rsp_pc = $urandom;
      ifetch_req_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // asynchronous reset in the middle of a stalled handshake
    do_reset();
    ifetch_req_ready = 0; cycle();
    ifetch_req_ready = 0;
    chk("E before reset valid", 32'(req_valid[0]), 32'd1);
    #3 reset_n = 0;
    #1;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("E p%0d async valid", p), 32'(req_valid[p]), 32'd0);
      chk($sformatf("E p%0d async active", p), 32'(act_w[p]), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
